logic_unit_seq: RTL
===================

Name: logic_unit_seq

Overview:
- Parametrised, multi-cycle successor to the fixed 32-bit per-bit gate arrays used in the ALU datapath.
- Performs AND, OR, XOR or NOR on two WIDTH-bit operands, one SLICE-bit chunk per clock.
- Uses a start/busy/done handshake so the multi-cycle ALU controller can sequence it like the other iterative units (multiplier, divider).
- Trades latency for a small, width-independent gate count.

Parameters:
- WIDTH, 32: operand and result width in bits; must be a multiple of SLICE.
- SLICE, 8: bits processed per cycle; NSLICE = WIDTH/SLICE, and 1 <= NSLICE <= 64.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request a new operation; sampled only in IDLE
- op  input  2  operation select: 00 AND, 01 OR, 10 XOR, 11 NOR
- a  input  WIDTH  operand A; sampled on the start-accept edge
- b  input  WIDTH  operand B; sampled on the start-accept edge
- busy  output  1  high while in BUSY or DONE
- done  output  1  one-cycle pulse; result is valid from this cycle
- result  output  WIDTH  last completed result; held until the next completion

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (reset_n).
- Reset, taken immediately and independent of clk:
  - state = IDLE
  - busy = 0, done = 0, result = 0
  - slice index = 0
  - internal operand, op and accumulator registers = 0
- States are IDLE, BUSY and DONE; encoding is free.
- IDLE:
  - If start = 1 at a rising edge, latch a, b and op into internal registers, clear the accumulator, set index = 0 and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - Each edge writes op(a_reg, b_reg) over bits [index*SLICE +: SLICE] into the accumulator and increments index.
  - On the edge that writes slice NSLICE-1, load result from the completed accumulator value (including that final slice) and go to DONE.
- DONE:
  - done = 1 for exactly this cycle; then go to IDLE.
- Latency: if start is accepted at edge T, done is high in the cycle after edge T+NSLICE. With defaults that is 4 BUSY cycles plus 1 DONE cycle.
- Throughput: the next start is accepted at the earliest in the first IDLE cycle after DONE, giving NSLICE+2 cycles per operation.
- start is ignored in BUSY and DONE; it is not queued.
- Changes on a, b or op after the accept edge have no effect on the operation in flight.
- result never shows partial values: it holds the previous completion throughout BUSY and changes only on entry to DONE.
- NOR is bitwise ~(a|b) across the full WIDTH. No carry or any other inter-slice dependency exists.
- NSLICE = 1 (SLICE = WIDTH): BUSY lasts one cycle, then DONE.
- Index width is clog2(NSLICE), minimum 1 bit. index returns to 0 on leaving BUSY.
- reset_n asserted mid-operation aborts the operation: result returns to 0, and no done pulse is produced for the aborted operation.
- start held high continuously: one operation per NSLICE+2 cycles, and each accept samples the operands present at that edge.

Optional Feature:
- Macro: LOGIC_UNIT_ZERO_FLAG_EN.
- Defined:
  - Adds output port zero (1 bit).
  - zero is registered alongside result: loaded with (completed accumulator value == 0) on entry to DONE and held until the next completion.
  - zero resets to 1, consistent with result = 0.
- Undefined: no zero port and no comparator logic. All other behaviour is identical.

Test Plan:
- Defaults. op=01, a=0xF0F00000, b=0x00000F0F, start pulsed at edge T -> busy from T; done high in the cycle after edge T+4 with result=0xF0F00F0F; result=0 during BUSY.
- op=11, a=0, b=0 -> result=0xFFFFFFFF. Then op=00, a=0xFFFF0000, b=0x00FFFF00 -> result=0x00FF0000. Then op=10, a=0xAAAAAAAA, b=0xFFFFFFFF -> result=0x55555555.
- Start with a=0x12345678, b=0, op=01. Drive a=0xFFFFFFFF and pulse start during BUSY -> second start ignored; result=0x12345678; exactly one done pulse.
- Start an operation, then assert reset_n=0 on the second BUSY cycle without waiting for a clock edge -> outputs cleared immediately (busy=0, result=0); no done pulse follows; a fresh operation after release completes correctly.
- WIDTH=16, SLICE=16, op=10, a=0x00FF, b=0x0F0F -> done in the second cycle after the accept edge, result=0x0FF0. Repeat with WIDTH=64, SLICE=8: done after 9 cycles.
- LOGIC_UNIT_ZERO_FLAG_EN defined: op=00, a=0xFF00FF00, b=0x00FF00FF -> result=0 and zero=1. Then op=01 on the same operands -> result=0xFFFFFFFF and zero=0. zero=1 after reset.

Source files
------------

// File: rtl/logic_unit_seq.sv
// logic_unit_seq: multi-cycle AND/OR/XOR/NOR unit, one SLICE-bit chunk per clock, start/busy/done handshake
// Ports: clk, reset_n (async active-low), start, op (00 AND, 01 OR, 10 XOR, 11 NOR), a, b,
//        busy (BUSY or DONE), done (one-cycle pulse), result (held until next completion),
//        zero (result == 0, only when LOGIC_UNIT_ZERO_FLAG_EN is defined)
module logic_unit_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [1:0] op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, res_q, res_d;
  logic [SLICE-1:0] sa, sb, sf;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
  logic zero_q, zero_d;
`endif
  always_comb begin
    sa = a_q[idx_q*SLICE +: SLICE];
    sb = b_q[idx_q*SLICE +: SLICE];
    sf = op_q == 2'b00 ? sa & sb : op_q == 2'b01 ? sa | sb : op_q == 2'b10 ? sa ^ sb : ~(sa | sb);
    state_d = state_q;
    idx_d = idx_q;
    op_d = op_q;
    a_d = a_q;
    b_d = b_q;
    acc_d = acc_q;
    res_d = res_q;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    zero_d = zero_q;
`endif
    if (state_q == IDLE) begin
      if (start) begin
        a_d = a;
        b_d = b;
        op_d = op;
        acc_d = '0;
        idx_d = '0;
        state_d = BUSY;
      end
    end else if (state_q == BUSY) begin
      acc_d[idx_q*SLICE +: SLICE] = sf;
      idx_d = idx_q + 1'b1;
      if (idx_q == IW'(NSLICE - 1)) begin
        idx_d = '0;
        res_d = acc_d;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
        zero_d = acc_d == '0;
`endif
        state_d = DONE;
      end
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      res_q <= '0;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
      zero_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
      res_q <= res_d;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
      zero_q <= zero_d;
`endif
    end
  end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign result = res_q;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
  assign zero = zero_q;
`endif
endmodule
